// File: rtl/ps2_arrow_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_arrow_tracker
// Brief    : Assembles PS/2 set-2 byte streams (E0/F0 prefixes) into 16-bit
//            scancodes, tracks the held state of the four arrow keys and
//            pulses on fresh presses. Partial sequences are dropped after an
//            idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_arrow_tracker #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        code_valid,
  output logic [15:0] code,
  output logic        code_break,
  output logic        left,
  output logic        down,
  output logic        right,
  output logic        up,
  output logic [3:0]  arrow_press,
  output logic        seq_abort
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] c_PFX_EXT = 8'hE0;
  localparam logic [7:0] c_PFX_BRK = 8'hF0;

  // A zero timeout means "never abort"; the last-count value is then unused.
  localparam logic             c_TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_code_valid;
  logic [15:0]      r_code;
  logic             r_code_break;
  logic [3:0]       r_lvl;       // {up, right, down, left}
  logic [3:0]       r_press;
  logic             r_abort;

  state_t           w_next;
  logic             w_done;
  logic             w_ext;
  logic             w_brk;
  logic [3:0]       w_hit;
  logic [3:0]       w_lvl_next;

  // Decode the incoming byte against the current prefix state.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (in_byte == c_PFX_EXT)      w_next = ST_EXT;
          else if (in_byte == c_PFX_BRK) w_next = ST_BRK;
          else                           w_done = 1'b1;
        end
        ST_EXT: begin
          if (in_byte == c_PFX_BRK)      w_next = ST_EXT_BRK;
          else if (in_byte != c_PFX_EXT) begin
            w_done = 1'b1;
            w_ext  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          // An E0 after F0 restarts as an extended make; the break is lost.
          if (in_byte == c_PFX_EXT)      w_next = ST_EXT;
          else if (in_byte != c_PFX_BRK) begin
            w_done = 1'b1;
            w_brk  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        default: begin // ST_EXT_BRK
          if (in_byte == c_PFX_EXT)      w_next = ST_EXT;
          else if (in_byte != c_PFX_BRK) begin
            w_done = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
            w_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Map a completed extended code onto an arrow bit and derive new levels.
  always_comb begin
    w_hit = 4'b0000;
    if (w_ext) begin
      case (in_byte)
        8'h6B:   w_hit = 4'b0001;
        8'h72:   w_hit = 4'b0010;
        8'h74:   w_hit = 4'b0100;
        8'h75:   w_hit = 4'b1000;
        default: w_hit = 4'b0000;
      endcase
    end
    w_lvl_next = r_lvl;
    if (w_done) begin
      w_lvl_next = w_brk ? (r_lvl & ~w_hit) : (r_lvl | w_hit);
    end
  end

  // Sequence FSM, idle timeout and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_code_valid <= 1'b0;
      r_code       <= 16'h0000;
      r_code_break <= 1'b0;
      r_lvl        <= 4'b0000;
      r_press      <= 4'b0000;
      r_abort      <= 1'b0;
    end else begin
      r_code_valid <= w_done;
      r_press      <= 4'b0000;
      r_abort      <= 1'b0;
      if (w_done) begin
        r_code       <= {(w_ext ? c_PFX_EXT : 8'h00), in_byte};
        r_code_break <= w_brk;
        r_lvl        <= w_lvl_next;
        r_press      <= w_lvl_next & ~r_lvl;
      end
      // A byte arriving on the final count cycle is processed, not aborted.
      if (in_valid) begin
        r_state <= w_next;
        r_cnt   <= '0;
      end else if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (c_TMO_EN && (r_cnt == c_TMO_LAST)) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_abort <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign code_valid  = r_code_valid;
  assign code        = r_code;
  assign code_break  = r_code_break;
  assign left        = r_lvl[0];
  assign down        = r_lvl[1];
  assign right       = r_lvl[2];
  assign up          = r_lvl[3];
  assign arrow_press = r_press;
  assign seq_abort   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_arrow_tracker
// Brief    : Scoreboard bench for ps2_arrow_tracker. Stimulus pushes the
//            hand-computed response for each completed sequence or abort;
//            a monitor pops and compares whenever the DUT reports an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_arrow_tracker;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        code_valid;
  logic [15:0] code;
  logic        code_break;
  logic        left;
  logic        down;
  logic        right;
  logic        up;
  logic [3:0]  arrow_press;
  logic        seq_abort;

  typedef struct {
    logic        is_abort;
    logic [15:0] code;
    logic        brk;
    logic [3:0]  lvl;   // {up, right, down, left}
    logic [3:0]  press;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks;
  int   n_fail;

  ps2_arrow_tracker #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(16)
  ) u_dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .code_valid(code_valid),
    .code(code),
    .code_break(code_break),
    .left(left),
    .down(down),
    .right(right),
    .up(up),
    .arrow_press(arrow_press),
    .seq_abort(seq_abort)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_code(input logic [15:0] c, input logic brk,
                          input logic [3:0] lvl, input logic [3:0] press);
    exp_t e;
    e.is_abort = 1'b0;
    e.code     = c;
    e.brk      = brk;
    e.lvl      = lvl;
    e.press    = press;
    q_exp.push_back(e);
  endtask

  task automatic exp_abort(input logic [3:0] lvl);
    exp_t e;
    e.is_abort = 1'b1;
    e.code     = 16'h0000;
    e.brk      = 1'b0;
    e.lvl      = lvl;
    e.press    = 4'b0000;
    q_exp.push_back(e);
  endtask

  // Monitor: sample away from the active edge and score every DUT event.
  always @(negedge clk) begin
    if (resetn && (code_valid || seq_abort)) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: code_valid=%0b seq_abort=%0b code=0x%0h, expected no event",
                 code_valid, seq_abort, code);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("seq_abort", 32'(seq_abort), 32'(e.is_abort));
        chk("code_valid", 32'(code_valid), 32'(!e.is_abort));
        if (!e.is_abort) begin
          chk("code", 32'(code), 32'(e.code));
          chk("code_break", 32'(code_break), 32'(e.brk));
        end
        chk("arrow_press", 32'(arrow_press), 32'(e.press));
        chk("levels", 32'({up, right, down, left}), 32'(e.lvl));
      end
    end
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    idle(3);

    // Reset values.
    chk("rst_code_valid", 32'(code_valid), 32'd0);
    chk("rst_code", 32'(code), 32'h0000);
    chk("rst_outputs", 32'({code_break, up, right, down, left, arrow_press, seq_abort}), 32'd0);
    resetn = 1'b1;
    idle(2);

    // Up press, then release.
    send(8'hE0); send(8'h75);              exp_code(16'hE075, 1'b0, 4'b1000, 4'b1000);
    send(8'hE0); send(8'hF0); send(8'h75); exp_code(16'hE075, 1'b1, 4'b0000, 4'b0000);

    // Left, right, then typematic repeat of left.
    send(8'hE0); send(8'h6B);              exp_code(16'hE06B, 1'b0, 4'b0001, 4'b0001);
    send(8'hE0); send(8'h74);              exp_code(16'hE074, 1'b0, 4'b0101, 4'b0100);
    send(8'hE0); send(8'h6B);              exp_code(16'hE06B, 1'b0, 4'b0101, 4'b0000);

    // Non-extended arrow codes, plain break, duplicate E0.
    send(8'h75);                           exp_code(16'h0075, 1'b0, 4'b0101, 4'b0000);
    send(8'hF0); send(8'h1C);              exp_code(16'h001C, 1'b1, 4'b0101, 4'b0000);
    send(8'hE0); send(8'hE0); send(8'h72); exp_code(16'hE072, 1'b0, 4'b0111, 4'b0010);

    // Timeout after a lone E0, then a plain 72 leaves down untouched.
    send(8'hE0);                           exp_abort(4'b0111);
    idle(5);
    send(8'h72);                           exp_code(16'h0072, 1'b0, 4'b0111, 4'b0000);

    // Byte on the final count cycle is processed instead of aborting.
    send(8'hE0); send(8'hF0);
    idle(3);
    send(8'h74);                           exp_code(16'hE074, 1'b1, 4'b0011, 4'b0000);

    // 00/FF are ordinary codes; E0 after F0 discards the break.
    send(8'h00);                           exp_code(16'h0000, 1'b0, 4'b0011, 4'b0000);
    send(8'hFF);                           exp_code(16'h00FF, 1'b0, 4'b0011, 4'b0000);
    send(8'hF0); send(8'hE0); send(8'hF0); send(8'h6B);
                                           exp_code(16'hE06B, 1'b1, 4'b0010, 4'b0000);
    send(8'hF0); send(8'h72);              exp_code(16'h0072, 1'b1, 4'b0010, 4'b0000);

    // Back-to-back bytes complete on consecutive cycles.
    send(8'h11);                           exp_code(16'h0011, 1'b0, 4'b0010, 4'b0000);
    send(8'h22);                           exp_code(16'h0022, 1'b0, 4'b0010, 4'b0000);
    send(8'hE0); send(8'h75);              exp_code(16'hE075, 1'b0, 4'b1010, 4'b1000);
    idle(3);

    // Reset mid-sequence after E0,F0.
    send(8'h3A);                           exp_code(16'h003A, 1'b0, 4'b1010, 4'b0000);
    send(8'hE0); send(8'hF0);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_code_valid", 32'(code_valid), 32'd0);
    chk("midrst_code", 32'(code), 32'h0000);
    chk("midrst_outputs", 32'({code_break, up, right, down, left, arrow_press, seq_abort}), 32'd0);
    resetn = 1'b1;
    send(8'h74);                           exp_code(16'h0074, 1'b0, 4'b0000, 4'b0000);

    idle(8);
    chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
